// File: rtl/rv_pkg.sv
// Shared encodings for the memory stage: FSM states, ResultSrc values and
// the load/store Funct3 codes understood by the byte-lane logic.
package rv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_t;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory request/response port: the stage drives requests as master,
// the memory (or its model) answers as slave.
interface memory_stage_if;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemByteEn;
    logic        MemReady;
    logic        MemRValid;
    logic [31:0] MemRData;

    modport master (
        output MemReq, MemWe, MemAddr, MemWData, MemByteEn,
        input  MemReady, MemRValid, MemRData
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemWData, MemByteEn,
        output MemReady, MemRValid, MemRData
    );
endinterface

// File: rtl/load_store_align.sv
// Combinational byte-lane steering: store lane enables/replication, load lane
// extraction with sign/zero extension, and illegal size/alignment detection.
module load_store_align
    import rv_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        bad_access
);

    function automatic logic [31:0] sext8(input logic signed [7:0] v);
        return 32'(v);
    endfunction

    function automatic logic [31:0] sext16(input logic signed [15:0] v);
        return 32'(v);
    endfunction

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = '0;
        rdata_ext  = '0;
        bad_access = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_B: begin
                    byte_en    = 4'b0001 << addr_lo;
                    wdata_lane = {4{wdata[7:0]}};
                end
                F3_H: begin
                    bad_access = addr_lo[0];
                    byte_en    = 4'b0011 << addr_lo;
                    wdata_lane = {2{wdata[15:0]}};
                end
                F3_W: begin
                    bad_access = |addr_lo;
                    byte_en    = 4'b1111;
                    wdata_lane = wdata;
                end
                default: bad_access = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B:  rdata_ext = sext8(rd_byte);
                F3_BU: rdata_ext = {24'd0, rd_byte};
                F3_H: begin
                    bad_access = addr_lo[0];
                    rdata_ext  = sext16(rd_half);
                end
                F3_HU: begin
                    bad_access = addr_lo[0];
                    rdata_ext  = {16'd0, rd_half};
                end
                F3_W: begin
                    bad_access = |addr_lo;
                    rdata_ext  = rdata;
                end
                default: bad_access = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/memory_stage.sv
// M stage of the pipeline: issues data-memory requests, stalls upstream until
// the access completes, and writes exactly one W-stage record per instruction.
module memory_stage
    import rv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ValidM,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  RdM,
    input  logic [31:0] PCPlus4M,
    memory_stage_if.master mem,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  RdW,
    output logic [31:0] PCPlus4W,
    output logic        MisalignW
);

    mem_state_t  state_q, state_d;
    logic        mem_op, bad_access, misalign, aligned_op;
    logic        mem_req, accept, load_done, complete, w_write;
    logic [3:0]  byte_en;
    logic [31:0] wdata_lane, rdata_ext;

    assign mem_op     = ValidM && (MemWriteM || ResultSrcM == RES_LOAD);
    assign misalign   = mem_op && bad_access;
    assign aligned_op = mem_op && !bad_access;

    load_store_align u_align (
        .is_store   (MemWriteM),
        .funct3     (Funct3M),
        .addr_lo    (ALUResultM[1:0]),
        .wdata      (WriteDataM),
        .rdata      (mem.MemRData),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .bad_access (bad_access)
    );

    // Request fields come straight from M; upstream is frozen by StallM so they hold in REQ.
    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (aligned_op) begin
                    mem_req = 1'b1;
                    if (!mem.MemReady)  state_d = ST_REQ;
                    else if (!MemWriteM) state_d = ST_WAIT;
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
                if (mem.MemReady) state_d = MemWriteM ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (mem.MemRValid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) mem_req = 1'b0;
    end

    assign accept    = mem_req && mem.MemReady;
    assign load_done = (state_q == ST_WAIT) && mem.MemRValid;
    assign complete  = (accept && MemWriteM) || load_done;
    assign StallM    = !rst && aligned_op && !complete;
    assign w_write   = ValidM && !StallM;

    assign mem.MemReq    = mem_req;
    assign mem.MemWe     = MemWriteM;
    assign mem.MemAddr   = {ALUResultM[31:2], 2'b00};
    assign mem.MemWData  = wdata_lane;
    assign mem.MemByteEn = byte_en;

    // M -> W boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            RegWriteW  <= 1'b0;
            MisalignW  <= 1'b0;
            ResultSrcW <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RdW        <= '0;
            PCPlus4W   <= '0;
        end else begin
            state_q   <= state_d;
            RegWriteW <= w_write && RegWriteM && !misalign;
            MisalignW <= w_write && misalign;
            if (w_write) begin
                ResultSrcW <= ResultSrcM;
                ALUResultW <= ALUResultM;
                ReadDataW  <= load_done ? rdata_ext : '0;
                RdW        <= RdM;
                PCPlus4W   <= PCPlus4M;
            end
        end
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have M-stage inputs: ValidM 1; RegWriteM 1; ResultSrcM 2 (00 ALU, 01 load, 10 PC+4); MemWriteM 1; Funct3M 3; ALUResultM 32 (address or result); WriteDataM 32; RdM 5; PCPlus4M 32.
REQ-003 SHALL have memory port: MemReq out 1; MemWe out 1; MemAddr out 32 (word-aligned); MemWData out 32; MemByteEn out 4; MemReady in 1 (request accepted); MemRValid in 1; MemRData in 32.
REQ-004 SHALL have outputs: StallM 1 (freeze upstream stages); RegWriteW 1; ResultSrcW 2; ALUResultW 32; ReadDataW 32; RdW 5; PCPlus4W 32; MisalignW 1.

Function
REQ-005 Memory op SHALL mean ValidM && (MemWriteM || ResultSrcM==01); all other instructions pass with StallM=0 and 1-cycle latency into W registers.
REQ-006 FSM SHALL have states IDLE, REQ, WAIT; reset state IDLE.
REQ-007 MemReq SHALL be 1 when (IDLE && aligned memory op) or REQ; acceptance = MemReq && MemReady in the same cycle.
REQ-008 IDLE: aligned memory op not accepted -> REQ; load accepted -> WAIT; store accepted -> stays IDLE.
REQ-009 REQ: MemReq, MemWe, MemAddr, MemWData, MemByteEn SHALL stay stable until acceptance; then load -> WAIT, store -> IDLE.
REQ-010 WAIT: MemReq=0; on MemRValid -> IDLE, capturing extended data; MemRValid outside WAIT SHALL be ignored.
REQ-011 StallM SHALL be 1 while a memory op is present and not completing; completion = store acceptance or WAIT && MemRValid; StallM=0 in the completion cycle.
REQ-012 Store lanes: SB ByteEn=0001<<addr[1:0], data byte replicated x4; SH ByteEn=0011<<addr[1:0], halfword replicated x2; SW ByteEn=1111.
REQ-013 Load extraction: LB/LBU from byte lane addr[1:0], LH/LHU from halfword addr[1], LW whole word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-014 Misaligned (half with addr[0]=1, word with addr[1:0]!=00) SHALL issue no request, no stall, and write W with RegWriteW=0, MisalignW=1 for one cycle.
REQ-015 MemAddr SHALL be {ALUResultM[31:2],2'b00}; MemWe=MemWriteM.
REQ-016 W registers SHALL update every cycle: completing or non-memory instruction -> M values (ReadDataW=extended load data, else 0); while StallM=1 or ValidM=0 -> bubble (RegWriteW=0, MisalignW=0).
REQ-017 Exactly one W-stage write SHALL occur per instruction regardless of stall length.
REQ-018 Unsupported Funct3 on a memory op SHALL be treated as misaligned (REQ-014).

Reset
REQ-019 rst SHALL force state IDLE and zero all W outputs on the next edge; MemReq and StallM SHALL be 0 during any cycle with rst=1.
REQ-020 rst mid-REQ/WAIT SHALL abandon the access; a later stray MemRValid SHALL be ignored.

Structure
REQ-021 Shared package rv_pkg SHALL hold the FSM state enum, ResultSrc encodings and load/store Funct3 constants.
REQ-022 Byte-lane/extension logic SHALL be one combinational sub-module, load_store_align.

Verification
REQ-023 SW addr 0x100, data 0xDEADBEEF, MemReady=1 immediately -> one MemReq cycle, ByteEn 1111, StallM=0, RegWriteW=0 next cycle.
REQ-024 LB addr 0x203, MemRData=0x80xxxxxx, MemReady after 2 cycles, MemRValid 3 cycles later -> StallM high 5 cycles, request stable while waiting, ReadDataW=0xFFFFFF80, one RegWriteW pulse.
REQ-025 LHU addr 0x202, MemRData=0x8001xxxx -> ReadDataW=0x00008001; SH addr 0x202 data 0x1234 -> ByteEn 1100, MemWData 0x12341234.
REQ-026 LW addr 0x102 -> no MemReq, StallM=0, MisalignW=1, RegWriteW=0.
REQ-027 ADD back-to-back with load stalled in WAIT -> ADD held, written to W exactly once after load, RdW order preserved.
REQ-028 rst asserted in WAIT, then MemRValid -> state IDLE, outputs zero, no W write.
